lhs_csr_packer: RTL and testbench
=================================

# lhs_csr_packer

Upstream LHS stage for the SpMM accelerator. Accepts a dense N×N LHS matrix one row per cycle, drops zero elements, and builds the compressed row-pointer / column / data stream consumed by the SpMM LHS port (`lhs_ptr`, `lhs_col`, `lhs_data`, `lhs_start`). The whole matrix is buffered before emission, so the row-pointer vector is complete and constant on every emitted beat. Downstream readiness (`lhs_ready_ns`) drives `out_ready`.

## Interface
- N, 16: matrix dimension; power of two, ≥4. lgN = clog2(N); dbLgN = 2·clog2(N).
- W, 8: element width, unsigned.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  `in_row` holds a valid dense row.
- in_ready  out  1  packer accepts a row this cycle.
- in_row  in  N×W  dense row; element j is column j.
- out_valid  out  1  current beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_start  out  1  high with the first beat of a matrix only.
- out_last  out  1  high with the final beat of a matrix.
- out_ptr  out  N×dbLgN  `out_ptr[i]` = number of nonzeros in rows 0..i-1 (row start offset).
- out_col  out  N×lgN  column index per slot.
- out_data  out  N×W  value per slot.
- out_count  out  lgN+1  valid slots in this beat, 0..N.
- out_nnz  out  dbLgN+1  total nonzeros in the matrix, 0..N².

## Operation
- Element is zero iff all W bits are 0; nonzeros are kept in row-major order (row ascending, column ascending within a row).
- Internal store: N² entries of {col, data}, write pointer `wp` (dbLgN+1 bits), row counter `rc` (lgN+1 bits), beat counter `bc`.
- States:
  - IDLE: `in_ready`=1, `out_valid`=0. On an accepted row, do the COLLECT row action and go to COLLECT. If N=1 the first row is also the last row, so go directly to EMIT.
  - COLLECT: `in_ready`=1. Per accepted row r:
    - k = popcount(nonzero mask);
    - nonzero with rank m is written to entry `wp`+m;
    - `ptr[r]` ← `wp`;
    - `wp` ← `wp`+k;
    - `rc` ← `rc`+1.
    - After row N-1 is accepted, go to EMIT.
  - EMIT: `in_ready`=0, `out_valid`=1.
    - Beat b, slot j = entry b·N+j if b·N+j < `wp`; otherwise col 0, data 0.
    - `out_count` = min(N, `wp`−b·N).
    - Beats emitted = max(1, ceil(`wp`/N)).
    - `out_start` = (b==0); `out_last` = (b==final).
    - `bc` advances on `out_valid`&&`out_ready`.
    - Handshake on the last beat → IDLE, and all counters clear.
- `out_ptr` and `out_nnz` are registered and held constant for all of EMIT; they are zero in IDLE and COLLECT.
- Empty matrix (`wp`=0): exactly one beat, `out_count`=0, `out_start`=`out_last`=1, all `out_ptr`=0.
- Full matrix (`wp`=N²): N beats, each `out_count`=N; `out_nnz`=N².

## Timing
- Reset (async): state IDLE; `in_ready`=1; `out_valid`, `out_start`, `out_last`=0; `out_ptr`, `out_col`, `out_data`, `out_count`, `out_nnz`=0; `wp`, `rc`, `bc`=0. Store contents are don't-care.
- Reset mid-COLLECT or mid-EMIT abandons the matrix; no partial output follows.
- One row accepted per cycle when `in_valid`=1. Gaps (`in_valid`=0) stall without effect.
- Row N-1 accepted at edge t → `out_valid`=1 from t+1. First beat available 1 cycle after the last row.
- `out_valid` never drops in EMIT until the last handshake. Beat contents stay stable while `out_valid`&&!`out_ready`.
- Last handshake at edge t → `in_ready`=1 at t+1. A new matrix's first row can be accepted at edge t+1; no back-to-back overlap.
- Zero-bubble throughput: N row cycles + ceil(nnz/N) beat cycles + 1.

## Test plan
- Identity (N=16, diagonal=1):
  - `out_ptr[i]`=i, `out_nnz`=16;
  - one beat, `out_col[j]`=j, `out_data[j]`=1, `out_count`=16;
  - `out_start`=`out_last`=1.
- All-zero matrix → one beat:
  - `out_count`=0, `out_nnz`=0, all `out_ptr`=0;
  - all `out_data`=0, `out_start`=`out_last`=1.
- Dense all-0xFF matrix:
  - `out_ptr[i]`=16·i, `out_nnz`=256;
  - 16 beats, each `out_count`=16;
  - beat b `out_col[j]`=j; `out_last` only on beat 15.
- Row 0 has 20 nonzeros… invalid (max N). Use instead:
  - rows 0–1 dense, rows 2–15 empty;
  - `out_ptr` = {0,16,32,32,…};
  - 2 beats, then row 2's first slot at beat 2 does not exist;
  - `out_nnz`=32.
- Partial last beat: 17 nonzeros (row 0 dense + row 5 col 3 = 0x07):
  - beat 1 has `out_count`=1, slot0 col 3 data 7, slots 1–15 zero;
  - `out_ptr[1..5]`=16, `out_ptr[6..15]`=17.
- Backpressure + reset:
  - hold `out_ready`=0 for 5 cycles on beat 0; contents stable, `out_valid` stays 1;
  - then assert reset mid-EMIT → next cycle `out_valid`=0, `in_ready`=1, `out_ptr`=0;
  - new identity matrix packs correctly.

Source files
------------

// File: rtl/lhs_csr_packer_if.sv
// rtl/lhs_csr_packer_if.sv - dense-row input and CSR beat output bundle for lhs_csr_packer
interface lhs_csr_packer_if #(
    parameter int N = 16,
    parameter int W = 8
);
    localparam int LGN   = $clog2(N);
    localparam int DBLGN = 2 * LGN;

    logic                        in_valid;
    logic                        in_ready;
    logic [N-1:0][W-1:0]         in_row;

    logic                        out_valid;
    logic                        out_ready;
    logic                        out_start;
    logic                        out_last;
    logic [N-1:0][DBLGN-1:0]     out_ptr;
    logic [N-1:0][LGN-1:0]       out_col;
    logic [N-1:0][W-1:0]         out_data;
    logic [LGN:0]                out_count;
    logic [DBLGN:0]              out_nnz;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_start, out_last,
               out_ptr, out_col, out_data, out_count, out_nnz
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_start, out_last,
               out_ptr, out_col, out_data, out_count, out_nnz
    );
endinterface

// File: rtl/lhs_csr_packer.sv
// rtl/lhs_csr_packer.sv - buffers a dense NxN matrix and emits it as CSR ptr/col/data beats
module lhs_csr_packer #(
    parameter int N = 16,
    parameter int W = 8
) (
    input logic             clock,
    input logic             reset,
    lhs_csr_packer_if.slave bus
);
    localparam int LGN   = $clog2(N);
    localparam int DBLGN = 2 * LGN;
    localparam int NN    = N * N;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    localparam logic [LGN:0]   RC_LAST = (LGN + 1)'(N - 1);
    localparam logic [LGN:0]   N_CNT   = (LGN + 1)'(N);
    localparam logic [DBLGN:0] N_WIDE  = (DBLGN + 1)'(N);

    logic [1:0]       state;
    logic [DBLGN:0]   wp;
    logic [LGN:0]     rc;
    logic [LGN:0]     bc;
    logic [DBLGN-1:0] ptr [N];

    logic [LGN-1:0]   col_mem  [NN];
    logic [W-1:0]     data_mem [NN];

    logic [N-1:0]     nz;
    logic [LGN:0]     rank [N];
    logic [LGN:0]     row_cnt;
    logic [DBLGN-1:0] wr_addr [N];

    logic             accept;
    logic             fire;
    logic             is_emit;
    logic [DBLGN:0]   remaining;
    logic             final_beat;

    assign is_emit    = (state == EMIT);
    assign accept     = bus.in_valid && !is_emit;
    assign fire       = is_emit && bus.out_ready;
    assign remaining  = wp - {bc, {LGN{1'b0}}};
    assign final_beat = (remaining <= N_WIDE);

    // Rank of each nonzero within its row gives its slot offset from wp.
    always_comb begin
        row_cnt = '0;
        for (int j = 0; j < N; j++) begin
            nz[j]      = |bus.in_row[j];
            rank[j]    = row_cnt;
            wr_addr[j] = wp[DBLGN-1:0] + {{(DBLGN - LGN - 1){1'b0}}, rank[j]};
            row_cnt    = row_cnt + {{LGN{1'b0}}, nz[j]};
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < N; j++) begin
            if (accept && nz[j]) begin
                col_mem[wr_addr[j]]  <= LGN'(j);
                data_mem[wr_addr[j]] <= bus.in_row[j];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wp    <= '0;
            rc    <= '0;
            bc    <= '0;
            for (int i = 0; i < N; i++) ptr[i] <= '0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        ptr[rc[LGN-1:0]] <= wp[DBLGN-1:0];
                        wp    <= wp + {{LGN{1'b0}}, row_cnt};
                        rc    <= rc + 1'b1;
                        state <= (rc == RC_LAST) ? EMIT : COLLECT;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (final_beat) begin
                            state <= IDLE;
                            wp    <= '0;
                            rc    <= '0;
                            bc    <= '0;
                        end else begin
                            bc <= bc + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !is_emit;
    assign bus.out_valid = is_emit;
    assign bus.out_start = is_emit && (bc == '0);
    assign bus.out_last  = is_emit && final_beat;
    assign bus.out_count = !is_emit ? '0 : (remaining > N_WIDE) ? N_CNT : remaining[LGN:0];
    assign bus.out_nnz   = is_emit ? wp : '0;

    // Slots past the last stored nonzero read as zero so a partial beat is clean.
    always_comb begin
        logic [DBLGN-1:0] rd_idx;
        rd_idx = '0;
        for (int j = 0; j < N; j++) begin
            rd_idx          = {bc[LGN-1:0], LGN'(j)};
            bus.out_ptr[j]  = is_emit ? ptr[j] : '0;
            bus.out_col[j]  = '0;
            bus.out_data[j] = '0;
            if (is_emit && ({1'b0, rd_idx} < wp)) begin
                bus.out_col[j]  = col_mem[rd_idx];
                bus.out_data[j] = data_mem[rd_idx];
            end
        end
    end
endmodule

// File: tb/tb_lhs_csr_packer.sv
// tb/tb_lhs_csr_packer.sv - directed self-checking bench for lhs_csr_packer
module tb_lhs_csr_packer;
    localparam int N     = 16;
    localparam int W     = 8;
    localparam int DBLGN = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lhs_csr_packer_if #(.N(N), .W(W)) bus ();
    lhs_csr_packer #(.N(N), .W(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    logic [N-1:0][W-1:0] mat [N];

    task automatic clear_mat();
        for (int r = 0; r < N; r++) mat[r] = '0;
    endtask

    // Entered and left on a falling edge; first beat is visible on return.
    task automatic send_matrix(input bit gaps);
        for (int r = 0; r < N; r++) begin
            if (gaps && (r % 3 == 1)) begin
                bus.in_valid = 1'b0;
                @(negedge clock);
            end
            bus.in_valid = 1'b1;
            bus.in_row   = mat[r];
            @(negedge clock);
        end
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        vectors++; if ({bus.out_start, bus.out_last} !== 2'b00) begin miscompares++; $display("FAIL reset_start_last: got %b expected 00", {bus.out_start, bus.out_last}); end
        vectors++; if (bus.out_count !== '0 || bus.out_nnz !== '0) begin miscompares++; $display("FAIL reset_count_nnz: got %0d/%0d expected 0/0", bus.out_count, bus.out_nnz); end
        vectors++; if (bus.out_ptr !== '0 || bus.out_col !== '0 || bus.out_data !== '0) begin miscompares++; $display("FAIL reset_vectors: got ptr %h col %h data %h expected all zero", bus.out_ptr, bus.out_col, bus.out_data); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_identity(input bit gaps);
        clear_mat();
        for (int r = 0; r < N; r++) mat[r][r] = 8'd1;
        send_matrix(gaps);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL identity_valid: got %b expected 1", bus.out_valid); end
        vectors++; if ({bus.out_start, bus.out_last} !== 2'b11) begin miscompares++; $display("FAIL identity_start_last: got %b expected 11", {bus.out_start, bus.out_last}); end
        vectors++; if (bus.out_count !== 5'd16) begin miscompares++; $display("FAIL identity_count: got %0d expected 16", bus.out_count); end
        vectors++; if (bus.out_nnz !== 9'd16) begin miscompares++; $display("FAIL identity_nnz: got %0d expected 16", bus.out_nnz); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (bus.out_ptr[i] !== DBLGN'(i)) begin miscompares++; $display("FAIL identity_ptr[%0d]: got %0d expected %0d", i, bus.out_ptr[i], i); end
            vectors++; if (bus.out_col[i] !== 4'(i) || bus.out_data[i] !== 8'd1) begin miscompares++; $display("FAIL identity_slot[%0d]: got col %0d data %0d expected col %0d data 1", i, bus.out_col[i], bus.out_data[i], i); end
        end
        @(negedge clock);
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL identity_done: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_zero();
        clear_mat();
        send_matrix(1'b0);
        vectors++; if (bus.out_valid !== 1'b1 || {bus.out_start, bus.out_last} !== 2'b11) begin miscompares++; $display("FAIL zero_flags: got valid %b start/last %b expected 1 11", bus.out_valid, {bus.out_start, bus.out_last}); end
        vectors++; if (bus.out_count !== '0 || bus.out_nnz !== '0) begin miscompares++; $display("FAIL zero_count_nnz: got %0d/%0d expected 0/0", bus.out_count, bus.out_nnz); end
        vectors++; if (bus.out_ptr !== '0 || bus.out_data !== '0 || bus.out_col !== '0) begin miscompares++; $display("FAIL zero_vectors: got ptr %h col %h data %h expected all zero", bus.out_ptr, bus.out_col, bus.out_data); end
        @(negedge clock);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_single_beat: got valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_dense();
        for (int r = 0; r < N; r++) mat[r] = '1;
        send_matrix(1'b0);
        vectors++; if (bus.out_nnz !== 9'd256) begin miscompares++; $display("FAIL dense_nnz: got %0d expected 256", bus.out_nnz); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (bus.out_ptr[i] !== DBLGN'(16 * i)) begin miscompares++; $display("FAIL dense_ptr[%0d]: got %0d expected %0d", i, bus.out_ptr[i], 16 * i); end
        end
        for (int b = 0; b < N; b++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_count !== 5'd16) begin miscompares++; $display("FAIL dense_beat%0d: got valid %b count %0d expected 1 16", b, bus.out_valid, bus.out_count); end
            vectors++; if (bus.out_start !== (b == 0) || bus.out_last !== (b == 15)) begin miscompares++; $display("FAIL dense_flags%0d: got start %b last %b expected %b %b", b, bus.out_start, bus.out_last, b == 0, b == 15); end
            for (int j = 0; j < N; j++) begin
                vectors++; if (bus.out_col[j] !== 4'(j) || bus.out_data[j] !== 8'hFF) begin miscompares++; $display("FAIL dense_slot%0d[%0d]: got col %0d data %h expected col %0d data ff", b, j, bus.out_col[j], bus.out_data[j], j); end
            end
            @(negedge clock);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL dense_end: got valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_two_rows();
        clear_mat();
        for (int j = 0; j < N; j++) begin
            mat[0][j] = 8'(j + 1);
            mat[1][j] = 8'(8'h80 + j);
        end
        send_matrix(1'b0);
        vectors++; if (bus.out_nnz !== 9'd32) begin miscompares++; $display("FAIL tworow_nnz: got %0d expected 32", bus.out_nnz); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (bus.out_ptr[i] !== ((i == 0) ? 8'd0 : (i == 1) ? 8'd16 : 8'd32)) begin miscompares++; $display("FAIL tworow_ptr[%0d]: got %0d", i, bus.out_ptr[i]); end
        end
        for (int b = 0; b < 2; b++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_count !== 5'd16 || bus.out_last !== (b == 1)) begin miscompares++; $display("FAIL tworow_beat%0d: got valid %b count %0d last %b expected 1 16 %b", b, bus.out_valid, bus.out_count, bus.out_last, b == 1); end
            for (int j = 0; j < N; j++) begin
                vectors++; if (bus.out_col[j] !== 4'(j) || bus.out_data[j] !== mat[b][j]) begin miscompares++; $display("FAIL tworow_slot%0d[%0d]: got col %0d data %h expected col %0d data %h", b, j, bus.out_col[j], bus.out_data[j], j, mat[b][j]); end
            end
            @(negedge clock);
        end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL tworow_no_beat2: got valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_partial();
        clear_mat();
        for (int j = 0; j < N; j++) mat[0][j] = 8'(8'h20 + j);
        mat[5][3] = 8'h07;
        send_matrix(1'b0);
        vectors++; if (bus.out_nnz !== 9'd17) begin miscompares++; $display("FAIL partial_nnz: got %0d expected 17", bus.out_nnz); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (bus.out_ptr[i] !== ((i == 0) ? 8'd0 : (i <= 5) ? 8'd16 : 8'd17)) begin miscompares++; $display("FAIL partial_ptr[%0d]: got %0d", i, bus.out_ptr[i]); end
        end
        vectors++; if (bus.out_count !== 5'd16 || bus.out_last !== 1'b0 || bus.out_data[15] !== 8'h2F) begin miscompares++; $display("FAIL partial_beat0: got count %0d last %b data15 %h expected 16 0 2f", bus.out_count, bus.out_last, bus.out_data[15]); end
        @(negedge clock);
        vectors++; if (bus.out_count !== 5'd1 || bus.out_last !== 1'b1 || bus.out_start !== 1'b0) begin miscompares++; $display("FAIL partial_beat1_flags: got count %0d last %b start %b expected 1 1 0", bus.out_count, bus.out_last, bus.out_start); end
        vectors++; if (bus.out_col[0] !== 4'd3 || bus.out_data[0] !== 8'h07) begin miscompares++; $display("FAIL partial_slot0: got col %0d data %h expected col 3 data 07", bus.out_col[0], bus.out_data[0]); end
        for (int j = 1; j < N; j++) begin
            vectors++; if (bus.out_col[j] !== '0 || bus.out_data[j] !== '0) begin miscompares++; $display("FAIL partial_pad[%0d]: got col %0d data %h expected 0 00", j, bus.out_col[j], bus.out_data[j]); end
        end
        @(negedge clock);
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL partial_done: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_backpressure_reset();
        clear_mat();
        for (int j = 0; j < N; j++) mat[0][j] = 8'(j + 1);
        mat[5][3] = 8'h07;
        bus.out_ready = 1'b0;
        send_matrix(1'b0);
        for (int c = 0; c < 5; c++) begin
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_start !== 1'b1 || bus.out_count !== 5'd16) begin miscompares++; $display("FAIL stall%0d_flags: got valid %b start %b count %0d expected 1 1 16", c, bus.out_valid, bus.out_start, bus.out_count); end
            vectors++; if (bus.out_data[15] !== 8'd16 || bus.out_col[15] !== 4'd15 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall%0d_data: got data %0d col %0d ready %b expected 16 15 0", c, bus.out_data[15], bus.out_col[15], bus.in_ready); end
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midemit_reset: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
        vectors++; if (bus.out_ptr !== '0 || bus.out_nnz !== '0) begin miscompares++; $display("FAIL midemit_ptr: got ptr %h nnz %0d expected 0 0", bus.out_ptr, bus.out_nnz); end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midemit_no_output: got valid %b expected 0", bus.out_valid); end
        test_identity(1'b0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_identity(1'b1);
        test_zero();
        test_dense();
        test_two_rows();
        test_partial();
        test_backpressure_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
